// File: rtl/srb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srb_pkg
// Description : Shared types and limits for the switchable register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package srb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAVING    = 2'd1,
        RESTORING = 2'd2
    } srb_state_e;

    localparam int MAX_N = 16;

endpackage : srb_pkg
`default_nettype wire

// File: rtl/srb_cell.sv
`default_nettype none
// ============================================================================
// Module      : srb_cell
// Description : One bank register; priority clear > store > restore > hold.
// Revision    : 1.0 - initial release
// ============================================================================
module srb_cell
    import srb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             restore,
    input  logic [WIDTH-1:0] restore_data,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (restore) begin
            q <= restore_data;
        end
    end

endmodule : srb_cell
`default_nettype wire

// File: rtl/switchable_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : switchable_register_bank
// Description : N-register bank with shared S bus, addressed A-bus read port
//               and shadow bank with SAVE/RESTORE sequencer.
//               Build option SRB_WRITE_BYPASS_EN: A bus forwards S bus on a
//               same-cycle write to the addressed register.
// Revision    : 1.0 - initial release
// ============================================================================
module switchable_register_bank
    import srb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int AW    = $clog2(N)
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [N-1:0]       SR,
    input  logic [WIDTH-1:0]   S_bus,
    output logic [N*WIDTH-1:0] Q,
    input  logic [AW-1:0]      RA,
    output logic [WIDTH-1:0]   A_bus,
    input  logic               SAVE,
    input  logic               RESTORE,
    output logic               BUSY,
    output logic               DONE
);

    localparam logic [1:0]    ST_IDLE      = IDLE;
    localparam logic [1:0]    ST_SAVING    = SAVING;
    localparam logic [1:0]    ST_RESTORING = RESTORING;
    localparam logic [AW-1:0] LAST_PTR     = AW'(N - 1);

    logic [1:0]       state;
    logic [AW-1:0]    ptr;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] regs   [N];
    logic [WIDTH-1:0] shadow [N];
    logic [WIDTH-1:0] a_mux;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            srb_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk          (CLK),
                .clr          (CLR),
                .load         (SR[gi]),
                .load_data    (S_bus),
                .restore      ((state == ST_RESTORING) && (ptr == AW'(gi))),
                .restore_data (shadow[gi]),
                .q            (regs[gi])
            );
            assign Q[gi*WIDTH +: WIDTH] = regs[gi];
        end
    endgenerate

    // Shadow captures the pre-edge register value, so a same-cycle store is not saved.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ptr <= '0;
                    if (SAVE) begin
                        state  <= ST_SAVING;
                        busy_r <= 1'b1;
                    end else if (RESTORE) begin
                        state  <= ST_RESTORING;
                        busy_r <= 1'b1;
                    end
                end
                ST_SAVING, ST_RESTORING: begin
                    if (state == ST_SAVING) begin
                        for (int i = 0; i < N; i++) begin
                            if (ptr == AW'(i)) begin
                                shadow[i] <= regs[i];
                            end
                        end
                    end
                    if (ptr == LAST_PTR) begin
                        state  <= ST_IDLE;
                        ptr    <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ptr    <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Addresses beyond N-1 match no register and read as zero.
    always_comb begin
        a_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (RA == AW'(i)) begin
`ifdef SRB_WRITE_BYPASS_EN
                a_mux = SR[i] ? S_bus : regs[i];
`else
                a_mux = regs[i];
`endif
            end
        end
    end

    assign A_bus = a_mux;
    assign BUSY  = busy_r;
    assign DONE  = done_r;

endmodule : switchable_register_bank
`default_nettype wire

// File: tb/tb_switchable_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_switchable_register_bank
// Description : Self-checking bench with a countdown-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switchable_register_bank;

    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int AW    = 2;

    logic               CLK = 1'b0;
    logic               CLR = 1'b0;
    logic [N-1:0]       SR = '0;
    logic [WIDTH-1:0]   S_bus = '0;
    logic [N*WIDTH-1:0] Q;
    logic [AW-1:0]      RA = '0;
    logic [WIDTH-1:0]   A_bus;
    logic               SAVE = 1'b0;
    logic               RESTORE = 1'b0;
    logic               BUSY;
    logic               DONE;

    int checks = 0;
    int errors = 0;

    switchable_register_bank #(
        .WIDTH (WIDTH),
        .N     (N)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .SR      (SR),
        .S_bus   (S_bus),
        .Q       (Q),
        .RA      (RA),
        .A_bus   (A_bus),
        .SAVE    (SAVE),
        .RESTORE (RESTORE),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    // Reference model: a copy job is a kind plus a count of copy cycles left.
    logic [WIDTH-1:0] m_regs   [N];
    logic [WIDTH-1:0] m_shadow [N];
    int               m_left  = 0;
    bit               m_is_save = 1'b0;
    bit               m_done  = 1'b0;
    bit               m_valid = 1'b0;

    function automatic logic [N*WIDTH-1:0] model_q();
        logic [N*WIDTH-1:0] v;
        for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = m_regs[i];
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] model_a();
        logic [WIDTH-1:0] v;
        if (int'(RA) >= N) return '0;
        v = m_regs[RA];
`ifdef SRB_WRITE_BYPASS_EN
        if (SR[RA]) v = S_bus;
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [N*WIDTH-1:0] act,
                       input logic [N*WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        logic [WIDTH-1:0] nxt [N];
        int k;
        if (CLR) begin
            for (int i = 0; i < N; i++) begin
                m_regs[i]   = '0;
                m_shadow[i] = '0;
            end
            m_left  = 0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int i = 0; i < N; i++) nxt[i] = SR[i] ? S_bus : m_regs[i];
            m_done = 1'b0;
            if (m_left > 0) begin
                k = N - m_left;
                if (m_is_save) m_shadow[k] = m_regs[k];
                else if (!SR[k]) nxt[k] = m_shadow[k];
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (SAVE) begin
                m_left = N;  m_is_save = 1'b1;
            end else if (RESTORE) begin
                m_left = N;  m_is_save = 1'b0;
            end
            for (int i = 0; i < N; i++) m_regs[i] = nxt[i];
        end
        #1;
        if (m_valid) begin
            chk("model_q", Q, model_q());
            chk("model_a_bus", {48'd0, A_bus}, {48'd0, model_a()});
            chk("model_busy", {63'd0, BUSY}, {63'd0, (m_left > 0)});
            chk("model_done", {63'd0, DONE}, {63'd0, m_done});
        end
    end

    task automatic tick(input logic [N-1:0] sr, input logic [WIDTH-1:0] sb,
                        input logic sv, input logic rs, input logic clr);
        @(negedge CLK);
        SR = sr;  S_bus = sb;  SAVE = sv;  RESTORE = rs;  CLR = clr;
        @(posedge CLK);
        #2;
    endtask

    task automatic count_run(input int resave, output int b, output int d);
        b = 0;
        d = 0;
        for (int i = 0; i < 8; i++) begin
            b += int'(BUSY);
            d += int'(DONE);
            tick('0, '0, (i < resave), 1'b0, 1'b0);
        end
    endtask

    initial begin
        int b, d;

        tick('0, '0, 0, 0, 1);
        chk("reset_q", Q, '0);
        chk("reset_busy_done", {62'd0, BUSY, DONE}, 64'd0);

        tick(4'b0010, 16'hBEEF, 0, 0, 0);
        chk("write_one", Q, 64'h0000_0000_BEEF_0000);
        RA = 2'd1;
        #1 chk("read_ra1", {48'd0, A_bus}, 64'h0000_0000_0000_BEEF);

        tick(4'b1111, 16'h1234, 0, 0, 0);
        repeat (5) tick('0, '0, 0, 0, 0);
        chk("broadcast_hold", Q, 64'h1234_1234_1234_1234);

        tick(4'b0001, 16'd1, 0, 0, 0);
        tick(4'b0010, 16'd2, 0, 0, 0);
        tick(4'b0100, 16'd3, 0, 0, 0);
        tick(4'b1000, 16'd4, 0, 0, 0);
        tick('0, '0, 1, 0, 0);
        count_run(0, b, d);
        chk("save_busy_cycles", 64'(b), 64'd4);
        chk("save_done_pulses", 64'(d), 64'd1);
        tick(4'b1111, 16'h0000, 0, 0, 0);
        chk("overwrite_zero", Q, 64'd0);
        tick('0, '0, 0, 1, 0);
        count_run(0, b, d);
        chk("restore_busy_cycles", 64'(b), 64'd4);
        chk("restore_done_pulses", 64'(d), 64'd1);
        chk("restore_values", Q, 64'h0004_0003_0002_0001);

        tick(4'b1111, 16'h0000, 0, 0, 0);
        tick('0, '0, 0, 1, 0);
        tick('0, '0, 0, 0, 0);
        tick('0, '0, 0, 0, 0);
        tick(4'b0100, 16'hAAAA, 0, 0, 0);
        repeat (3) tick('0, '0, 0, 0, 0);
        chk("restore_store_wins", Q, 64'h0004_AAAA_0002_0001);

        tick(4'b1111, 16'h5555, 0, 0, 0);
        tick('0, '0, 1, 1, 0);
        count_run(2, b, d);
        chk("both_req_busy_cycles", 64'(b), 64'd4);
        chk("resave_done_once", 64'(d), 64'd1);
        tick(4'b1111, 16'h0000, 0, 0, 0);
        tick('0, '0, 0, 1, 0);
        count_run(0, b, d);
        chk("save_won_shadow", Q, 64'h5555_5555_5555_5555);

        tick(4'b1111, 16'h7777, 0, 0, 0);
        tick('0, '0, 1, 0, 0);
        tick('0, '0, 0, 0, 0);
        tick('0, '0, 0, 0, 1);
        chk("clr_mid_save_flags", {62'd0, BUSY, DONE}, 64'd0);
        chk("clr_mid_save_q", Q, 64'd0);
        tick('0, '0, 0, 1, 0);
        count_run(0, b, d);
        chk("restore_after_clr", Q, 64'd0);

        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] sr;
            sr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            RA = AW'($urandom);
            tick(sr, WIDTH'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 149) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_switchable_register_bank
`default_nettype wire
